gnn_0_example_save: RTL and testbench

GNN_0_EXAMPLE_SAVE -- requirements
Module: gnn_0_example_save

---
 rtl/gnn_0_example_save.sv | 209 ++++++++++++++++++++
 tb/tb_gnn_0_example_save.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_0_example_save.sv
// gnn_0_example_save
//
// Save engine: copies buf_len words out of the on-chip 512-entry result
// buffer into an AXI4-Stream feeding an AXI write master, then reports
// completion once the write master has finished.
//
// Ports
//   kernel_clk / kernel_rst_n     : clock, synchronous active-low reset
//   ap_start / ap_done            : one-cycle start request / done pulse
//   ctrl_addr_offset              : DRAM base address
//   ctrl_instruction              : [47:32] buf_start, [63:48] buf_len (words),
//                                   [79:64] dram_start, [95:80] dram_bytes
//   save_read_buffer_valid/_addr  : buffer read enable and word address
//   save_read_buffer_data         : read data, valid one cycle after enable
//   wr_start / wr_done            : write-master start / completion pulses
//   wr_addr_offset                : base + dram_start
//   wr_xfer_size_in_bytes         : dram_bytes
//   s_axis_*                      : stream of buffer words to the write master
module gnn_0_example_save #(
  parameter int SAVE_INST_LENGTH   = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst_n,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [SAVE_INST_LENGTH-1:0]   ctrl_instruction,
  output logic                          save_read_buffer_valid,
  output logic [8:0]                    save_read_buffer_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] save_read_buffer_data,
  output logic                          wr_start,
  input  logic                          wr_done,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr_offset,
  output logic [C_XFER_SIZE_WIDTH-1:0]  wr_xfer_size_in_bytes,
  output logic                          s_axis_tvalid,
  input  logic                          s_axis_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] s_axis_tdata,
  output logic                          s_axis_tlast
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DECODE  = 2'd1,
    S_STREAM  = 2'd2,
    S_WAIT_WR = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Latched instruction fields
  logic [8:0]                    r_buf_start;
  logic [15:0]                   r_buf_len;
  logic [15:0]                   r_dram_start;
  logic [15:0]                   r_dram_bytes;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr_offset;

  // Progress counters: words read from the buffer, beats sent on the stream
  logic [15:0] r_rd_cnt;
  logic [15:0] r_beat_cnt;
  logic        r_wr_done_seen;
  logic        r_ap_done;

  // Read pipeline and 2-entry output FIFO
  logic                          r_rd_vld_p1;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]                    r_count;
  logic                          r_wptr;
  logic                          r_rptr;

  logic       w_start_acc;
  logic       w_pop;
  logic       w_rd_en;
  logic [2:0] w_occ_after_pop;
  logic       w_last_beat;
  logic       w_wr_start;
  logic       w_done_set;
  logic [8:0] w_rd_addr;
  logic       w_unused_inst;

  // Bits of the instruction word this engine does not consume.
  assign w_unused_inst = ^{ctrl_instruction[31:0], ctrl_instruction[47:41]};

  assign w_start_acc = (r_state == S_IDLE) && ap_start;
  assign w_pop       = (r_count != 2'd0) && s_axis_tready;

  // Words already committed (buffered or in flight) once this cycle's pop
  // leaves; a new read is allowed only if it still fits in the FIFO.
  assign w_occ_after_pop = 3'(r_count) + 3'(r_rd_vld_p1) - 3'(w_pop);
  assign w_rd_en = (r_state == S_STREAM) && (r_rd_cnt < r_buf_len) &&
                   (w_occ_after_pop < 3'd2);

  // The FIFO head is always beat number r_beat_cnt.
  assign w_last_beat = w_pop && (r_beat_cnt == r_buf_len - 16'd1);

  assign w_rd_addr = r_buf_start + r_rd_cnt[8:0];

  always_comb begin
    w_next_state = r_state;
    w_wr_start   = 1'b0;
    w_done_set   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (ap_start) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        if (r_buf_len == 16'd0) begin
          w_done_set   = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_wr_start   = 1'b1;
          w_next_state = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_last_beat) begin
          if (r_wr_done_seen || wr_done) begin
            w_done_set   = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_WAIT_WR;
          end
        end
      end
      S_WAIT_WR: begin
        if (wr_done) begin
          w_done_set   = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge kernel_clk) begin
    if (!kernel_rst_n) r_state <= S_IDLE;
    else               r_state <= w_next_state;
  end

  always_ff @(posedge kernel_clk) begin
    if (!kernel_rst_n) begin
      r_buf_start    <= '0;
      r_buf_len      <= '0;
      r_dram_start   <= '0;
      r_dram_bytes   <= '0;
      r_addr_offset  <= '0;
      r_rd_cnt       <= '0;
      r_beat_cnt     <= '0;
      r_wr_done_seen <= 1'b0;
      r_ap_done      <= 1'b0;
    end else begin
      r_ap_done <= w_done_set;
      if (w_start_acc) begin
        r_buf_start    <= ctrl_instruction[40:32];
        r_buf_len      <= ctrl_instruction[63:48];
        r_dram_start   <= ctrl_instruction[79:64];
        r_dram_bytes   <= ctrl_instruction[95:80];
        r_addr_offset  <= ctrl_addr_offset;
        r_rd_cnt       <= '0;
        r_beat_cnt     <= '0;
        r_wr_done_seen <= 1'b0;
      end else begin
        if (w_rd_en) r_rd_cnt   <= r_rd_cnt + 16'd1;
        if (w_pop)   r_beat_cnt <= r_beat_cnt + 16'd1;
        // The write master may finish before the stream drains; remember it.
        if (wr_done && (r_state != S_IDLE)) r_wr_done_seen <= 1'b1;
      end
    end
  end

  // ---- stage p0 -> p1: buffer read issued, data returns next cycle ----
  always_ff @(posedge kernel_clk) begin
    if (!kernel_rst_n) r_rd_vld_p1 <= 1'b0;
    else               r_rd_vld_p1 <= w_rd_en;
  end

  // ---- stage p1 -> FIFO: returning word captured, head drives the stream ----
  always_ff @(posedge kernel_clk) begin
    if (!kernel_rst_n) begin
      r_count <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      r_count <= r_count + 2'(r_rd_vld_p1) - 2'(w_pop);
      if (r_rd_vld_p1) r_wptr <= ~r_wptr;
      if (w_pop)       r_rptr <= ~r_rptr;
    end
  end

  always_ff @(posedge kernel_clk) begin
    if (r_rd_vld_p1) r_fifo_data[r_wptr] <= save_read_buffer_data;
  end

  assign save_read_buffer_valid = w_rd_en;
  assign save_read_buffer_addr  = w_rd_en ? w_rd_addr : 9'd0;

  assign s_axis_tvalid = (r_count != 2'd0);
  assign s_axis_tdata  = s_axis_tvalid ? r_fifo_data[r_rptr] : '0;
  assign s_axis_tlast  = s_axis_tvalid && (r_beat_cnt == r_buf_len - 16'd1);

  assign wr_start              = w_wr_start;
  assign ap_done               = r_ap_done;
  assign wr_addr_offset        = r_addr_offset + C_M_AXI_ADDR_WIDTH'(r_dram_start);
  assign wr_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(r_dram_bytes);

endmodule

// File: tb/tb_gnn_0_example_save.sv
module tb_gnn_0_example_save;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int XW = 32;
  localparam int IL = 96;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ap_start = 1'b0;
  logic          ap_done;
  logic [AW-1:0] ctrl_addr_offset = '0;
  logic [IL-1:0] ctrl_instruction = '0;
  logic          save_read_buffer_valid;
  logic [8:0]    save_read_buffer_addr;
  logic [DW-1:0] save_read_buffer_data = '0;
  logic          wr_start;
  logic          wr_done = 1'b0;
  logic [AW-1:0] wr_addr_offset;
  logic [XW-1:0] wr_xfer_size_in_bytes;
  logic          s_axis_tvalid;
  logic          s_axis_tready = 1'b0;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tlast;

  gnn_0_example_save #(
    .SAVE_INST_LENGTH  (IL),
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_XFER_SIZE_WIDTH (XW)
  ) dut (
    .kernel_clk            (clk),
    .kernel_rst_n          (rst_n),
    .ap_start              (ap_start),
    .ap_done               (ap_done),
    .ctrl_addr_offset      (ctrl_addr_offset),
    .ctrl_instruction      (ctrl_instruction),
    .save_read_buffer_valid(save_read_buffer_valid),
    .save_read_buffer_addr (save_read_buffer_addr),
    .save_read_buffer_data (save_read_buffer_data),
    .wr_start              (wr_start),
    .wr_done               (wr_done),
    .wr_addr_offset        (wr_addr_offset),
    .wr_xfer_size_in_bytes (wr_xfer_size_in_bytes),
    .s_axis_tvalid         (s_axis_tvalid),
    .s_axis_tready         (s_axis_tready),
    .s_axis_tdata          (s_axis_tdata),
    .s_axis_tlast          (s_axis_tlast)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] mkword(input logic [8:0] a);
    mkword = {32'hA5A5_0000 | 32'(a), 448'd0, 16'hBEEF, 7'd0, a};
  endfunction

  // Buffer memory: data one cycle after the enable, junk otherwise.
  always @(posedge clk)
    save_read_buffer_data <= save_read_buffer_valid ? mkword(save_read_buffer_addr)
                                                    : {16{32'hDEADBEEF}};

  // Activity log sampled on the falling edge.
  logic [8:0]    rd_addr_q [$];
  int            rd_cyc_q  [$];
  logic [DW-1:0] beat_d_q  [$];
  logic          beat_l_q  [$];
  int            beat_cyc_q[$];
  int            n_wr_start = 0;
  int            wr_start_cyc = 0;
  int            n_done = 0;
  int            done_cyc = 0;
  int            stall_err = 0;
  logic          prev_stall = 1'b0;
  logic          prev_rst = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(negedge clk) begin
    if (save_read_buffer_valid) begin
      rd_addr_q.push_back(save_read_buffer_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (s_axis_tvalid && s_axis_tready) begin
      beat_d_q.push_back(s_axis_tdata);
      beat_l_q.push_back(s_axis_tlast);
      beat_cyc_q.push_back(cyc);
    end
    if (wr_start) begin n_wr_start++; wr_start_cyc = cyc; end
    if (ap_done)  begin n_done++;     done_cyc = cyc;     end
    if (prev_stall && prev_rst && rst_n &&
        (!s_axis_tvalid || s_axis_tdata !== prev_data || s_axis_tlast !== prev_last))
      stall_err++;
    prev_stall = s_axis_tvalid && !s_axis_tready;
    prev_data  = s_axis_tdata;
    prev_last  = s_axis_tlast;
    prev_rst   = rst_n;
  end

  int start_cyc = 0;
  int wd_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] off, input logic [15:0] bs, input logic [15:0] bl,
                       input logic [15:0] ds, input logic [15:0] db);
    ctrl_addr_offset = off;
    ctrl_instruction = {db, ds, bl, bs, 32'hFFFF_FFFF};
    ap_start  = 1'b1;
    start_cyc = cyc;
    tick();
    ap_start = 1'b0;
  endtask

  task automatic pulse_wr_done();
    wr_done = 1'b1;
    wd_cyc  = cyc;
    tick();
    wr_done = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beat_d_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (beat_d_q.size() < target) begin
      errors++;
      $display("FAIL wait_beats timeout: got %0d beats, required %0d", beat_d_q.size(), target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ap_done, wr_start, save_read_buffer_valid, s_axis_tvalid, s_axis_tlast} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {ap_done, wr_start, save_read_buffer_valid, s_axis_tvalid, s_axis_tlast});
    end
    checks++;
    if (save_read_buffer_addr !== 9'd0 || s_axis_tdata !== '0) begin
      errors++;
      $display("FAIL reset_data: addr %0h tdata %0h required 0", save_read_buffer_addr, s_axis_tdata);
    end
    checks++;
    if (wr_addr_offset !== '0 || wr_xfer_size_in_bytes !== '0) begin
      errors++;
      $display("FAIL reset_fields: off %0h size %0h required 0", wr_addr_offset, wr_xfer_size_in_bytes);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [8:0] ea [4] = '{9'h010, 9'h011, 9'h012, 9'h013};
    int rb = rd_addr_q.size();
    int bb = beat_d_q.size();
    int wsb = n_wr_start;
    int db = n_done;
    int k;
    s_axis_tready = 1'b1;
    issue(64'h0, 16'h010, 16'd4, 16'h0000, 16'h0040);
    k = start_cyc;
    // A second start while busy carries an empty instruction; it must be ignored.
    ctrl_instruction = '0;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    wait_beats(bb + 4, 30);
    checks++;
    if (n_done != db) begin
      errors++;
      $display("FAIL basic_early_done: got %0d done pulses required 0", n_done - db);
    end
    pulse_wr_done();
    tick();
    tick();
    checks++;
    if (rd_addr_q.size() - rb != 4) begin
      errors++;
      $display("FAIL basic_reads: got %0d required 4", rd_addr_q.size() - rb);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_addr_q[rb+i] !== ea[i] || rd_cyc_q[rb+i] != k + 2 + i) begin
        errors++;
        $display("FAIL basic_rd%0d: addr %0h @%0d required %0h @%0d", i, rd_addr_q[rb+i],
                 rd_cyc_q[rb+i], ea[i], k + 2 + i);
      end
      checks++;
      if (beat_d_q[bb+i] !== mkword(ea[i]) || beat_l_q[bb+i] !== (i == 3) ||
          beat_cyc_q[bb+i] != k + 4 + i) begin
        errors++;
        $display("FAIL basic_beat%0d: data %0h last %0b @%0d required %0h last %0b @%0d", i,
                 beat_d_q[bb+i][31:0], beat_l_q[bb+i], beat_cyc_q[bb+i], mkword(ea[i]) & 32'hFFFFFFFF,
                 (i == 3), k + 4 + i);
      end
    end
    checks++;
    if (n_wr_start - wsb != 1 || wr_start_cyc != k + 1) begin
      errors++;
      $display("FAIL basic_wr_start: got %0d pulses @%0d required 1 @%0d", n_wr_start - wsb,
               wr_start_cyc, k + 1);
    end
    checks++;
    if (n_done - db != 1 || done_cyc != wd_cyc + 1) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses @%0d required 1 @%0d", n_done - db, done_cyc, wd_cyc + 1);
    end
  endtask

  task automatic test_wrap();
    logic [8:0] ea [4] = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
    int rb = rd_addr_q.size();
    int bb = beat_d_q.size();
    int db = n_done;
    s_axis_tready = 1'b1;
    issue(64'h0, 16'h01FE, 16'd4, 16'h0000, 16'h0040);
    wait_beats(bb + 4, 30);
    pulse_wr_done();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_addr_q[rb+i] !== ea[i] || beat_d_q[bb+i] !== mkword(ea[i])) begin
        errors++;
        $display("FAIL wrap_word%0d: addr %0h data %0h required addr %0h", i, rd_addr_q[rb+i],
                 beat_d_q[bb+i][8:0], ea[i]);
      end
    end
    checks++;
    if (n_done - db != 1) begin
      errors++;
      $display("FAIL wrap_done: got %0d required 1", n_done - db);
    end
  endtask

  task automatic test_zero_len();
    int rb = rd_addr_q.size();
    int bb = beat_d_q.size();
    int wsb = n_wr_start;
    int db = n_done;
    int k;
    issue(64'h0, 16'h0050, 16'd0, 16'h0000, 16'h0000);
    k = start_cyc;
    repeat (5) tick();
    checks++;
    if (n_wr_start != wsb || rd_addr_q.size() != rb || beat_d_q.size() != bb) begin
      errors++;
      $display("FAIL zero_activity: wr_start %0d reads %0d beats %0d required 0 0 0",
               n_wr_start - wsb, rd_addr_q.size() - rb, beat_d_q.size() - bb);
    end
    checks++;
    if (n_done - db != 1 || done_cyc != k + 2) begin
      errors++;
      $display("FAIL zero_done: got %0d @%0d required 1 @%0d", n_done - db, done_cyc, k + 2);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pat = 32'b1011_0010_0110_1101_0011_1001_0101_1100;
    int rb = rd_addr_q.size();
    int bb = beat_d_q.size();
    int db = n_done;
    int sb = stall_err;
    int max_out = 0;
    int out;
    int n = 0;
    issue(64'h0, 16'h00F0, 16'd8, 16'h0010, 16'h0200);
    while (beat_d_q.size() < bb + 8 && n < 100) begin
      s_axis_tready = pat[n % 32];
      tick();
      out = (rd_addr_q.size() - rb) - (beat_d_q.size() - bb);
      if (out > max_out) max_out = out;
      n++;
    end
    s_axis_tready = 1'b1;
    repeat (3) tick();
    pulse_wr_done();
    tick();
    checks++;
    if (beat_d_q.size() - bb != 8 || rd_addr_q.size() - rb != 8) begin
      errors++;
      $display("FAIL stall_count: beats %0d reads %0d required 8 8", beat_d_q.size() - bb,
               rd_addr_q.size() - rb);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (beat_d_q[bb+i] !== mkword(9'(9'h0F0 + i)) || beat_l_q[bb+i] !== (i == 7)) begin
        errors++;
        $display("FAIL stall_beat%0d: data %0h last %0b required addr %0h last %0b", i,
                 beat_d_q[bb+i][8:0], beat_l_q[bb+i], 9'h0F0 + i, (i == 7));
      end
    end
    checks++;
    if (stall_err != sb) begin
      errors++;
      $display("FAIL stall_stable: got %0d unstable beats required 0", stall_err - sb);
    end
    checks++;
    if (max_out > 2) begin
      errors++;
      $display("FAIL stall_buffered: got %0d words required at most 2", max_out);
    end
    checks++;
    if (n_done - db != 1) begin
      errors++;
      $display("FAIL stall_done: got %0d required 1", n_done - db);
    end
  endtask

  task automatic test_early_wr_done();
    int bb = beat_d_q.size();
    int db = n_done;
    s_axis_tready = 1'b1;
    issue(64'h0000_0000_1000_0000, 16'h0020, 16'd4, 16'h0200, 16'h0100);
    checks++;
    if (wr_addr_offset !== 64'h0000_0000_1000_0200 || wr_xfer_size_in_bytes !== 32'h100 ||
        wr_start !== 1'b1) begin
      errors++;
      $display("FAIL early_decode: off %0h size %0h wr_start %0b required 10000200 100 1",
               wr_addr_offset, wr_xfer_size_in_bytes, wr_start);
    end
    tick();
    pulse_wr_done();
    wait_beats(bb + 4, 30);
    tick();
    tick();
    checks++;
    if (n_done - db != 1 || done_cyc != beat_cyc_q[bb+3] + 1) begin
      errors++;
      $display("FAIL early_done: got %0d @%0d required 1 @%0d", n_done - db, done_cyc,
               beat_cyc_q[bb+3] + 1);
    end
    checks++;
    if (wr_addr_offset !== 64'h0000_0000_1000_0200 || wr_xfer_size_in_bytes !== 32'h100) begin
      errors++;
      $display("FAIL early_hold: off %0h size %0h required 10000200 100", wr_addr_offset,
               wr_xfer_size_in_bytes);
    end
  endtask

  task automatic test_reset_mid();
    int bb = beat_d_q.size();
    int rb;
    int db;
    int k;
    s_axis_tready = 1'b1;
    issue(64'h0, 16'h0180, 16'd8, 16'h0000, 16'h0200);
    wait_beats(bb + 3, 30);
    rst_n = 1'b0;
    s_axis_tready = 1'b0;
    tick();
    rb = rd_addr_q.size();
    db = n_done;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ap_done, wr_start, save_read_buffer_valid, s_axis_tvalid, s_axis_tlast} !== 5'b0 ||
          save_read_buffer_addr !== 9'd0 || s_axis_tdata !== '0 || wr_addr_offset !== '0) begin
        errors++;
        $display("FAIL midrst_out%0d: ctrl %b addr %0h off %0h required all 0", i,
                 {ap_done, wr_start, save_read_buffer_valid, s_axis_tvalid, s_axis_tlast},
                 save_read_buffer_addr, wr_addr_offset);
      end
      tick();
    end
    checks++;
    if (beat_d_q.size() - bb != 3 || rd_addr_q.size() != rb || n_done != db) begin
      errors++;
      $display("FAIL midrst_abort: beats %0d reads %0d done %0d required 3 0 0",
               beat_d_q.size() - bb, rd_addr_q.size() - rb, n_done - db);
    end
    // Release reset and start a new job on the very same edge.
    rst_n = 1'b1;
    s_axis_tready = 1'b1;
    bb = beat_d_q.size();
    issue(64'h0, 16'h01FF, 16'd2, 16'h0300, 16'h0080);
    k = start_cyc;
    wait_beats(bb + 2, 30);
    pulse_wr_done();
    tick();
    checks++;
    if (rd_addr_q[rb] !== 9'h1FF || rd_addr_q[rb+1] !== 9'h000 || rd_cyc_q[rb] != k + 2) begin
      errors++;
      $display("FAIL midrst_new_reads: %0h %0h @%0d required 1ff 000 @%0d", rd_addr_q[rb],
               rd_addr_q[rb+1], rd_cyc_q[rb], k + 2);
    end
    checks++;
    if (beat_d_q[bb] !== mkword(9'h1FF) || beat_d_q[bb+1] !== mkword(9'h000) ||
        beat_l_q[bb] !== 1'b0 || beat_l_q[bb+1] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_new_beats: %0h/%0b %0h/%0b required 1ff/0 000/1", beat_d_q[bb][8:0],
               beat_l_q[bb], beat_d_q[bb+1][8:0], beat_l_q[bb+1]);
    end
    checks++;
    if (n_done - db != 1 || wr_addr_offset !== 64'h300) begin
      errors++;
      $display("FAIL midrst_new_done: done %0d off %0h required 1 300", n_done - db, wr_addr_offset);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_stall();
    test_early_wr_done();
    test_reset_mid();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
